// File: rtl/branch_predictor_pkg.sv
// Shared order codes, counter constants and helpers
// for the branch predictor and its order decoder.
package branch_predictor_pkg;

   localparam int ORD_JALR = 12;
   localparam int ORD_JAL  = 30;
   localparam int ORD_BEQ  = 31;
   localparam int ORD_BNE  = 32;
   localparam int ORD_BLT  = 33;
   localparam int ORD_BGE  = 34;
   localparam int ORD_BLTU = 35;
   localparam int ORD_BGEU = 36;

   localparam logic [1:0] CTR_RST = 2'b01;

   function automatic logic [1:0] ctr_next(
      input logic [1:0] c,
      input logic       t
   );
      logic [1:0] n;
      n = c;
      if (t && c != 2'b11) n = c + 2'd1;
      if (!t && c != 2'b00) n = c - 2'd1;
      return n;
   endfunction

endpackage

// File: rtl/branch_predictor_order_decode.sv
// Combinational order classifier: branch / conditional / JALR.
// Replaces the old standalone classifier.
module bp_order_decode
   import branch_predictor_pkg::*;
#(
   parameter int ORDER_W = 6
) (
   input  logic [ORDER_W-1:0] i_order,
   output logic               o_is_branch,
   output logic               o_is_cond,
   output logic               o_is_jalr
);

   always_comb begin
      o_is_branch = 1'b0;
      o_is_cond   = 1'b0;
      o_is_jalr   = 1'b0;
      unique case (1'b1)
         (i_order == ORDER_W'(ORD_JALR)): begin
            o_is_branch = 1'b1;
            o_is_jalr   = 1'b1;
         end
         (i_order == ORDER_W'(ORD_JAL)): o_is_branch = 1'b1;
         (i_order == ORDER_W'(ORD_BEQ)),
         (i_order == ORDER_W'(ORD_BNE)),
         (i_order == ORDER_W'(ORD_BLT)),
         (i_order == ORDER_W'(ORD_BGE)),
         (i_order == ORDER_W'(ORD_BLTU)),
         (i_order == ORDER_W'(ORD_BGEU)): begin
            o_is_branch = 1'b1;
            o_is_cond   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal / gshare direction predictor with order classification
// and commit-side accuracy statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int IDX_W   = 8,
   parameter int GHR_W   = 8,
   parameter int MODE    = 0,
   parameter int ORDER_W = 6,
   parameter int CNT_W   = 32
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               q_valid,
   input  logic [31:0]        q_pc,
   input  logic [ORDER_W-1:0] q_order,
   output logic               p_valid,
   output logic               p_is_branch,
   output logic               p_is_jalr,
   output logic               p_taken,
   output logic [IDX_W-1:0]   p_index,
   input  logic               u_valid,
   input  logic               u_cond,
   input  logic [IDX_W-1:0]   u_index,
   input  logic               u_taken,
   input  logic               u_pred,
   input  logic               flush_in,
   output logic [CNT_W-1:0]   stat_total,
   output logic [CNT_W-1:0]   stat_miss
);

   localparam int N = 1 << IDX_W;

   logic [1:0]       r_tbl [N];
   logic [GHR_W-1:0] r_ghr;
   logic             r_p_valid;
   logic             r_p_br;
   logic             r_p_jalr;
   logic             r_p_taken;
   logic [IDX_W-1:0] r_p_idx;
   logic [CNT_W-1:0] r_total;
   logic [CNT_W-1:0] r_miss;

   logic             w_br;
   logic             w_cond;
   logic             w_jalr;
   logic             w_jal;
   logic             w_taken;
   logic             w_query;
   logic [IDX_W-1:0] w_hist;
   logic [IDX_W-1:0] w_idx;
   logic             w_unused_pc;

   bp_order_decode #(
      .ORDER_W (ORDER_W)
   ) u_dec (
      .i_order     (q_order),
      .o_is_branch (w_br),
      .o_is_cond   (w_cond),
      .o_is_jalr   (w_jalr)
   );

   assign w_unused_pc = ^{q_pc[31:IDX_W+2], q_pc[1:0]};

   assign w_hist  = (MODE == 1) ? IDX_W'(r_ghr) : '0;
   assign w_idx   = q_pc[IDX_W+1:2] ^ w_hist;
   assign w_jal   = w_br & ~w_cond & ~w_jalr;
   // Table read sees pre-update contents: no same-edge bypass.
   assign w_taken = w_jal | (w_cond & r_tbl[w_idx][1]);
   assign w_query = q_valid & ~flush_in;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         for (int i = 0; i < N; i++) r_tbl[i] <= CTR_RST;
         r_ghr     <= '0;
         r_p_valid <= 1'b0;
         r_p_br    <= 1'b0;
         r_p_jalr  <= 1'b0;
         r_p_taken <= 1'b0;
         r_p_idx   <= '0;
         r_total   <= '0;
         r_miss    <= '0;
      end else if (rdy_in) begin
         if (u_valid && u_cond) begin
            r_tbl[u_index] <= ctr_next(r_tbl[u_index], u_taken);
            if (MODE == 1) r_ghr <= GHR_W'({r_ghr, u_taken});
         end
         if (u_valid) begin
            r_total <= r_total + CNT_W'(1);
            if (u_taken != u_pred) r_miss <= r_miss + CNT_W'(1);
         end
         r_p_valid <= w_query;
         if (w_query) begin
            r_p_br    <= w_br;
            r_p_jalr  <= w_jalr;
            r_p_taken <= w_taken;
            r_p_idx   <= w_idx;
         end
      end
   end

   assign p_valid     = r_p_valid;
   assign p_is_branch = r_p_br;
   assign p_is_jalr   = r_p_jalr;
   assign p_taken     = r_p_taken;
   assign p_index     = r_p_idx;
   assign stat_total  = r_total;
   assign stat_miss   = r_miss;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised successor to the combinational branch classifier.
- Classifies the fetched order, as before.
- Adds a direction predictor: a table of 2-bit saturating counters, in bimodal or gshare mode, trained by resolved branches from commit.
- Sits between instruction fetch (query side) and the ROB/commit stage (update side). Also keeps prediction-accuracy counters.

Parameters:
- IDX_W, 8: log2 of table entries (256 counters).
- GHR_W, 8: global history length; must be <= IDX_W.
- MODE, 0: 0 = bimodal (index = pc[IDX_W+1:2]); 1 = gshare (index = pc[IDX_W+1:2] XOR zero-extended GHR).
- ORDER_W, 6: width of the decoded order code.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous reset, active-low.
- rdy_in  in  1  global enable; when low, no state changes and outputs hold.
- q_valid  in  1  fetch query valid.
- q_pc  in  32  PC of the queried instruction.
- q_order  in  ORDER_W  decoded order code.
- p_valid  out  1  prediction valid, one cycle after the query.
- p_is_branch  out  1  order is BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR.
- p_is_jalr  out  1  order is JALR (target unknown; fetch must stall).
- p_taken  out  1  predicted direction.
- p_index  out  IDX_W  table index used; travels with the instruction to commit.
- u_valid  in  1  resolved-branch update from commit.
- u_cond  in  1  update is a conditional branch (JAL/JALR updates count statistics only).
- u_index  in  IDX_W  index returned from p_index.
- u_taken  in  1  actual direction.
- u_pred  in  1  direction that was predicted.
- flush_in  in  1  pipeline flush; cancels the in-flight prediction.
- stat_total  out  CNT_W  resolved branches counted.
- stat_miss  out  CNT_W  mispredictions counted.

Behaviour:
- Reset (rst_in low at a clock edge):
  - All counters go to 2'b01 (weakly not-taken); GHR = 0.
  - p_valid, p_is_branch, p_is_jalr, p_taken = 0; p_index = 0.
  - stat_total and stat_miss = 0.
  - Reset mid-operation drops any pending prediction; no update is applied in that cycle.
- rdy_in low: table, GHR, stats and all outputs hold; query and update inputs are ignored.
- Query (1-cycle latency, registered outputs):
  - On an edge with q_valid=1 and flush_in=0, set p_valid=1.
  - p_is_branch is decoded from q_order.
  - p_taken rules:
    - JAL: 1.
    - JALR: 0, with p_is_jalr=1.
    - Conditional branch: MSB of counter[idx].
    - Non-branch: 0.
  - p_index = idx (computed per MODE).
  - If q_valid=0 or flush_in=1, p_valid=0 next cycle; the other outputs hold their last values.
  - Exactly one query per cycle; no backpressure.
- Update (takes effect at the edge):
  - If u_valid and u_cond: counter[u_index] increments when u_taken=1 (saturates at 2'b11) and decrements otherwise (saturates at 2'b00).
  - In MODE 1 with u_valid and u_cond: GHR <= {GHR[GHR_W-2:0], u_taken}.
  - In MODE 0 the GHR stays 0.
- Statistics:
  - Every u_valid: stat_total += 1.
  - If u_taken != u_pred: stat_miss += 1.
  - Both counters wrap modulo 2^CNT_W.
- Same-cycle query and update to the same index: the query reads the pre-update counter value (no bypass). The update still applies.
- Same-cycle query and update in gshare mode: the query uses the pre-update GHR.
- flush_in does not affect the table, GHR or stats; same-cycle updates are still applied.

Decomposition:
- Shared header (`include):
  - order-code defines: JALR=12, JAL=30, BEQ=31, BNE=32, BLT=33, BGE=34, BLTU=35, BGEU=36;
  - counter reset constant 2'b01.
  - Reused by the decoder, the RS and the ROB.
- Sub-module bp_order_decode: combinational order -> {is_branch, is_cond, is_jalr}. It replaces the old classifier.
- Counter table stays inline as a register array (synchronous write, combinational read).

Test Plan:
- Reset then query BEQ at pc=0x100 -> next cycle p_valid=1, p_is_branch=1, p_taken=0, p_index=0x40 (MODE 0).
- Two updates u_index=0x40, u_taken=1, u_cond=1, then query BEQ at pc=0x100 -> p_taken=1. Three more taken updates, then one not-taken -> still p_taken=1 (counter 2'b10, saturated on the way).
- Query JAL -> p_taken=1. Query JALR -> p_taken=0, p_is_jalr=1. Query ADD (order 1) -> p_is_branch=0, p_taken=0.
- Update and query at the same index and edge, counter at 01, u_taken=1 -> prediction is 0; the following query is 1.
- MODE=1: update sequence taken,taken,not-taken -> GHR=8'b110. Query pc=0x100 -> p_index=0x40^0x06=0x46.
- 5 updates with 2 u_taken!=u_pred -> stat_total=5, stat_miss=2.
- Pulse rdy_in=0 during an update -> no change. Assert flush_in with q_valid -> p_valid=0.
- Assert rst_in=0 mid-stream -> all counters read as weakly not-taken.
